rf_write_voter: RTL and testbench

- Parametrised successor to the two-core register-file write comparator in the fault-tolerant core cluster.
- Accepts NUM_CORES lockstep write ports (we/addr/data) from redundant cores and emits one registered, voted write to the shared register file.
- In DMR (2 cores), any disagreement is uncorrectable. In TMR (3 cores), single-lane faults are masked by majority and the faulty lane is flagged.
- Counts corrected and uncorrected events, runs a recovery request/acknowledge handshake, and latches a permanent fail state past a threshold.

---
 rtl/rf_write_voter.sv | 197 +++++++++++++++++++
 tb/tb_rf_write_voter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_voter.sv
// Voted register-file write port for 2 (DMR) or 3 (TMR) lockstep cores, with
// event counters, a recovery handshake and a sticky permanent-fail lock.
module rf_write_voter #(
    parameter int unsigned NUM_CORES      = 3,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned FAIL_THRESHOLD = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CORES-1:0]            we_i,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] data_i,
    input  logic                            clear_i,
    input  logic                            recover_ack_i,
    output logic                            we_o,
    output logic [ADDR_WIDTH-1:0]           addr_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            error_o,
    output logic [NUM_CORES-1:0]            faulty_lane_o,
    output logic [CNT_WIDTH-1:0]            corr_cnt_o,
    output logic [CNT_WIDTH-1:0]            uncorr_cnt_o,
    output logic                            recover_req_o,
    output logic                            fail_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    if (NUM_CORES != 2 && NUM_CORES != 3) begin : g_bad_cores
        $error("rf_write_voter: NUM_CORES must be 2 or 3");
    end
    if (FAIL_THRESHOLD < 1 || FAIL_THRESHOLD > (2**CNT_WIDTH) - 1) begin : g_bad_threshold
        $error("rf_write_voter: FAIL_THRESHOLD out of range");
    end

    logic [ADDR_WIDTH-1:0] lane_addr [NUM_CORES];
    logic [DATA_WIDTH-1:0] lane_data [NUM_CORES];

    for (genvar k = 0; k < NUM_CORES; k++) begin : g_lane
        assign lane_addr[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign lane_data[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Idle lanes agree regardless of addr/data; active lanes must match exactly.
    function automatic logic tuple_agree(
        input logic                  we_a,
        input logic                  we_b,
        input logic [ADDR_WIDTH-1:0] addr_a,
        input logic [ADDR_WIDTH-1:0] addr_b,
        input logic [DATA_WIDTH-1:0] data_a,
        input logic [DATA_WIDTH-1:0] data_b
    );
        return (!we_a && !we_b) || (we_a && we_b && addr_a == addr_b && data_a == data_b);
    endfunction

    logic                 all_agree_c;
    logic                 correctable_c;
    logic                 maj_hi_c;
    logic [NUM_CORES-1:0] fault_mask_c;

    if (NUM_CORES == 3) begin : g_tmr
        logic agree_01;
        logic agree_02;
        logic agree_12;
        assign agree_01 = tuple_agree(we_i[0], we_i[1], lane_addr[0], lane_addr[1],
                                      lane_data[0], lane_data[1]);
        assign agree_02 = tuple_agree(we_i[0], we_i[2], lane_addr[0], lane_addr[2],
                                      lane_data[0], lane_data[2]);
        assign agree_12 = tuple_agree(we_i[1], we_i[2], lane_addr[1], lane_addr[2],
                                      lane_data[1], lane_data[2]);
        // Agreement is transitive, so a correctable cycle has exactly one agreeing pair.
        assign all_agree_c   = agree_01 && agree_02;
        assign correctable_c = !all_agree_c && (agree_01 || agree_02 || agree_12);
        assign maj_hi_c      = !agree_01 && !agree_02;
        assign fault_mask_c  = {agree_01, agree_02, agree_12};
    end else begin : g_dmr
        assign all_agree_c   = tuple_agree(we_i[0], we_i[1], lane_addr[0], lane_addr[1],
                                           lane_data[0], lane_data[1]);
        assign correctable_c = 1'b0;
        assign maj_hi_c      = 1'b0;
        assign fault_mask_c  = '0;
    end

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [NUM_CORES-1:0]  faulty_q, faulty_d;
    logic [CNT_WIDTH-1:0]  corr_q, corr_d;
    logic [CNT_WIDTH-1:0]  uncorr_q, uncorr_d;
    logic                  req_q, req_d;
    logic                  fail_q, fail_d;
    logic [CNT_WIDTH-1:0]  uncorr_inc_c;

    assign uncorr_inc_c = (uncorr_q == '1) ? uncorr_q : uncorr_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            faulty_q <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
            req_q    <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            faulty_q <= faulty_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            req_q    <= req_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = 1'b0;
        faulty_d = faulty_q;
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        req_d    = req_q;
        fail_d   = fail_q;

        unique case (state_q)
            ST_RUN: begin
                if (all_agree_c) begin
                    we_d   = we_i[0];
                    addr_d = lane_addr[0];
                    data_d = lane_data[0];
                end else if (correctable_c) begin
                    we_d     = maj_hi_c ? we_i[1]      : we_i[0];
                    addr_d   = maj_hi_c ? lane_addr[1] : lane_addr[0];
                    data_d   = maj_hi_c ? lane_data[1] : lane_data[0];
                    err_d    = 1'b1;
                    faulty_d = faulty_q | fault_mask_c;
                    corr_d   = (corr_q == '1) ? corr_q : corr_q + CNT_WIDTH'(1);
                end else begin
                    err_d    = 1'b1;
                    uncorr_d = uncorr_inc_c;
                    if (uncorr_inc_c >= CNT_WIDTH'(FAIL_THRESHOLD)) begin
                        state_d = ST_LOCKED;
                        fail_d  = 1'b1;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_RECOVER;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                if (recover_ack_i) begin
                    state_d = ST_RUN;
                    req_d   = 1'b0;
                end
            end
            ST_LOCKED: begin
                fail_d = 1'b1;
                req_d  = 1'b0;
            end
            default: state_d = ST_RUN;
        endcase

        if (clear_i) begin
            faulty_d = '0;
            corr_d   = '0;
            uncorr_d = '0;
        end
    end

    assign we_o          = we_q;
    assign addr_o        = addr_q;
    assign data_o        = data_q;
    assign error_o       = err_q;
    assign faulty_lane_o = faulty_q;
    assign corr_cnt_o    = corr_q;
    assign uncorr_cnt_o  = uncorr_q;
    assign recover_req_o = req_q;
    assign fail_o        = fail_q;

endmodule

// File: tb/tb_rf_write_voter.sv
// Drives a DMR and a TMR voter from shared lane vectors and checks both against
// a lane-counting reference model every cycle, plus pinned literal expectations.
module tb_rf_write_voter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  we;
    logic [14:0] addr;
    logic [95:0] data;
    logic        clr;
    logic        ack;

    logic        d_we, d_err, d_req, d_fail;
    logic [4:0]  d_addr;
    logic [31:0] d_data;
    logic [1:0]  d_faulty;
    logic [7:0]  d_corr, d_uncorr;

    logic        t_we, t_err, t_req, t_fail;
    logic [4:0]  t_addr;
    logic [31:0] t_data;
    logic [2:0]  t_faulty;
    logic [7:0]  t_corr, t_uncorr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_write_voter #(.NUM_CORES(2)) u_dmr (
        .clk_i(clk), .rst_i(rst), .we_i(we[1:0]), .addr_i(addr[9:0]), .data_i(data[63:0]),
        .clear_i(clr), .recover_ack_i(ack),
        .we_o(d_we), .addr_o(d_addr), .data_o(d_data), .error_o(d_err),
        .faulty_lane_o(d_faulty), .corr_cnt_o(d_corr), .uncorr_cnt_o(d_uncorr),
        .recover_req_o(d_req), .fail_o(d_fail)
    );

    rf_write_voter #(.NUM_CORES(3)) u_tmr (
        .clk_i(clk), .rst_i(rst), .we_i(we), .addr_i(addr), .data_i(data),
        .clear_i(clr), .recover_ack_i(ack),
        .we_o(t_we), .addr_o(t_addr), .data_o(t_data), .error_o(t_err),
        .faulty_lane_o(t_faulty), .corr_cnt_o(t_corr), .uncorr_cnt_o(t_uncorr),
        .recover_req_o(t_req), .fail_o(t_fail)
    );

    // st: 0 = running, 1 = awaiting recovery ack, 2 = locked
    typedef struct {
        int          st;
        bit          we;
        int unsigned addr;
        int unsigned data;
        bit          err;
        int unsigned faulty;
        int unsigned corr;
        int unsigned uncorr;
        bit          req;
        bit          fail;
    } mstate_t;

    mstate_t md, mt;

    function automatic bit lanes_agree(input logic [2:0] w, input logic [14:0] a,
                                       input logic [95:0] d, input int i, input int j);
        if (!w[i] && !w[j]) return 1'b1;
        return w[i] && w[j] && a[i*5 +: 5] == a[j*5 +: 5] && d[i*32 +: 32] == d[j*32 +: 32];
    endfunction

    function automatic mstate_t step(input mstate_t s, input int n, input bit r,
                                     input logic [2:0] w, input logic [14:0] a,
                                     input logic [95:0] d, input bit c, input bit k);
        mstate_t o;
        int cnt [3];
        int best;
        int pick;
        int odd;
        o = s;
        o.we = 1'b0;
        o.err = 1'b0;
        if (r) begin
            o = '{0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0};
            return o;
        end
        if (s.st == 0) begin
            best = 0; pick = 0; odd = 0;
            for (int i = 0; i < n; i++) begin
                cnt[i] = 0;
                for (int j = 0; j < n; j++) if (lanes_agree(w, a, d, i, j)) cnt[i]++;
            end
            for (int i = n - 1; i >= 0; i--) begin
                if (cnt[i] >= best) begin best = cnt[i]; pick = i; end
                if (cnt[i] == 1) odd = i;
            end
            if (best == n) begin
                o.we = w[0]; o.addr = a[4:0]; o.data = d[31:0];
            end else if (n == 3 && best == 2) begin
                o.we = w[pick]; o.addr = a[pick*5 +: 5]; o.data = d[pick*32 +: 32];
                o.err = 1'b1;
                o.faulty = s.faulty | (1 << odd);
                o.corr = (s.corr < 255) ? s.corr + 1 : 255;
            end else begin
                o.err = 1'b1;
                o.uncorr = (s.uncorr < 255) ? s.uncorr + 1 : 255;
                if (o.uncorr >= 4) begin o.st = 2; o.fail = 1'b1; o.req = 1'b0; end
                else begin o.st = 1; o.req = 1'b1; end
            end
        end else if (s.st == 1) begin
            if (k) begin o.st = 0; o.req = 1'b0; end
        end
        if (c) begin o.corr = 0; o.uncorr = 0; o.faulty = 0; end
        return o;
    endfunction

    always @(posedge clk) begin
        md = step(md, 2, rst, we, addr, data, clr, ack);
        mt = step(mt, 3, rst, we, addr, data, clr, ack);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("dmr.we", 64'(d_we), 64'(md.we));
        chk("dmr.addr", 64'(d_addr), 64'(md.addr));
        chk("dmr.data", 64'(d_data), 64'(md.data));
        chk("dmr.err", 64'(d_err), 64'(md.err));
        chk("dmr.faulty", 64'(d_faulty), 64'(md.faulty));
        chk("dmr.corr", 64'(d_corr), 64'(md.corr));
        chk("dmr.uncorr", 64'(d_uncorr), 64'(md.uncorr));
        chk("dmr.req", 64'(d_req), 64'(md.req));
        chk("dmr.fail", 64'(d_fail), 64'(md.fail));
        chk("tmr.we", 64'(t_we), 64'(mt.we));
        chk("tmr.addr", 64'(t_addr), 64'(mt.addr));
        chk("tmr.data", 64'(t_data), 64'(mt.data));
        chk("tmr.err", 64'(t_err), 64'(mt.err));
        chk("tmr.faulty", 64'(t_faulty), 64'(mt.faulty));
        chk("tmr.corr", 64'(t_corr), 64'(mt.corr));
        chk("tmr.uncorr", 64'(t_uncorr), 64'(mt.uncorr));
        chk("tmr.req", 64'(t_req), 64'(mt.req));
        chk("tmr.fail", 64'(t_fail), 64'(mt.fail));
    end

    task automatic drive(input logic [2:0] w, input int unsigned a0, a1, a2,
                         input int unsigned d0, d1, d2);
        we   = w;
        addr = {5'(a2), 5'(a1), 5'(a0)};
        data = {32'(d2), 32'(d1), 32'(d0)};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ack = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lit reset dmr we", 64'(d_we), 64'd0);
        chk("lit reset tmr req", 64'(t_req), 64'd0);
        chk("lit reset tmr data", 64'(t_data), 64'd0);
        rst = 1'b0;

        // matching write
        drive(3'b111, 10, 10, 10, 100, 100, 100);
        tick();
        chk("lit dmr pass we", 64'(d_we), 64'd1);
        chk("lit dmr pass addr", 64'(d_addr), 64'd10);
        chk("lit dmr pass data", 64'(d_data), 64'd100);
        chk("lit dmr pass err", 64'(d_err), 64'd0);

        // lane1 address fault: uncorrectable in DMR, masked in TMR
        drive(3'b111, 10, 11, 10, 100, 100, 100);
        tick();
        chk("lit dmr fault we", 64'(d_we), 64'd0);
        chk("lit dmr fault err", 64'(d_err), 64'd1);
        chk("lit dmr fault uncorr", 64'(d_uncorr), 64'd1);
        chk("lit dmr fault req", 64'(d_req), 64'd1);
        chk("lit tmr mask faulty", 64'(t_faulty), 64'd2);
        drive(3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        chk("lit dmr err pulse", 64'(d_err), 64'd0);
        tick();
        tick();
        chk("lit dmr req held", 64'(d_req), 64'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("lit dmr req dropped", 64'(d_req), 64'd0);
        drive(3'b111, 10, 10, 10, 120, 120, 120);
        tick();
        chk("lit dmr resume we", 64'(d_we), 64'd1);
        chk("lit dmr resume data", 64'(d_data), 64'd120);

        // TMR single-lane data fault
        do_reset();
        drive(3'b111, 10, 10, 10, 120, 100, 100);
        tick();
        chk("lit tmr maj data", 64'(t_data), 64'd100);
        chk("lit tmr maj we", 64'(t_we), 64'd1);
        chk("lit tmr maj err", 64'(t_err), 64'd1);
        chk("lit tmr maj faulty", 64'(t_faulty), 64'd1);
        chk("lit tmr maj corr", 64'(t_corr), 64'd1);
        drive(3'b000, 1, 2, 3, 7, 8, 9);
        tick();
        chk("lit tmr idle err", 64'(t_err), 64'd0);

        // four uncorrectable events reach the fail threshold
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 10, 10, 10, 1, 2, 3);
            tick();
            if (i == 3) begin
                chk("lit tmr lock uncorr", 64'(t_uncorr), 64'd4);
                chk("lit tmr lock fail", 64'(t_fail), 64'd1);
                chk("lit tmr lock req", 64'(t_req), 64'd0);
            end
            drive(3'b000, 0, 0, 0, 0, 0, 0);
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        drive(3'b111, 10, 10, 10, 5, 5, 5);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("lit tmr locked we", 64'(t_we), 64'd0);
        chk("lit tmr fail sticky", 64'(t_fail), 64'd1);
        do_reset();
        chk("lit tmr fail reset", 64'(t_fail), 64'd0);

        // clear wins over a same-cycle single-lane fault
        drive(3'b111, 10, 10, 10, 7, 9, 7);
        tick();
        drive(3'b111, 10, 10, 10, 7, 7, 6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("lit clr corr", 64'(t_corr), 64'd0);
        chk("lit clr faulty", 64'(t_faulty), 64'd0);
        chk("lit clr err", 64'(t_err), 64'd1);
        chk("lit clr data", 64'(t_data), 64'd7);

        // reset while awaiting recovery
        do_reset();
        drive(3'b111, 10, 11, 10, 100, 100, 100);
        tick();
        chk("lit dmr recover req", 64'(d_req), 64'd1);
        do_reset();
        chk("lit rst recover req", 64'(d_req), 64'd0);
        chk("lit rst recover uncorr", 64'(d_uncorr), 64'd0);
        chk("lit rst recover data", 64'(d_data), 64'd0);
        drive(3'b111, 10, 10, 10, 55, 55, 55);
        tick();
        chk("lit rst resume we", 64'(d_we), 64'd1);
        chk("lit rst resume data", 64'(d_data), 64'd55);

        // corrected counter saturates
        do_reset();
        ack = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive(3'b111, 10, 10, 10, 3, 3, 4);
            tick();
        end
        ack = 1'b0;
        chk("lit corr saturate", 64'(t_corr), 64'd255);
        chk("lit corr faulty", 64'(t_faulty), 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
